// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared types, constants and helpers for ap_ctrl_perf_monitor.
package ap_mon_pkg;

    // Counter width the statistics record is built with; the top-level
    // CNT_W parameter must match it.
    localparam int CNT_W_DEF = 32;

    localparam logic [CNT_W_DEF-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W_DEF-1:0] LAT_MIN_INIT = '1;

    // Occupancy class of one channel's outstanding-start FIFO.
    typedef enum logic [1:0] {
        CH_EMPTY  = 2'd0,
        CH_ACTIVE = 2'd1,
        CH_FULL   = 2'd2
    } ch_state_e;

    // Per-channel statistics record.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] starts;
        logic [CNT_W_DEF-1:0] dones;
        logic [CNT_W_DEF-1:0] lat_last;
        logic [CNT_W_DEF-1:0] lat_min;
        logic [CNT_W_DEF-1:0] lat_max;
        logic [CNT_W_DEF-1:0] stall;
    } ch_stats_t;

    localparam ch_stats_t STATS_RESET = '{
        starts:   '0,
        dones:    '0,
        lat_last: '0,
        lat_min:  LAT_MIN_INIT,
        lat_max:  '0,
        stall:    '0
    };

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ap_mon_ts_fifo.sv
// ap_mon_ts_fifo: DEPTH x W circular FIFO holding start timestamps of one
// channel. The caller never pushes when full (unless popping in the same
// cycle) and never pops when empty.
module ap_mon_ts_fifo
    import ap_mon_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     head_o,
    output logic [OCC_W-1:0] occ_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    ch_state_e        state_q;
    ch_state_e        state_d;

    // Timestamp storage written on push.
    // NOTE: the storage array has no reset; occupancy gates every read, so
    // stale entries left over from before a reset are never observed.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; reset discards all outstanding entries.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_d;
        end
    end

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        occ_d = occ_q;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= CH_EMPTY;
        else          state_q <= state_d;
    end

    // FSM next state: the class follows the occupancy after this cycle.
    always_comb begin
        state_d = CH_ACTIVE;
        if (occ_d == '0)                state_d = CH_EMPTY;
        else if (occ_d == OCC_W'(DEPTH)) state_d = CH_FULL;
    end

    // FSM outputs.
    always_comb begin
        empty_o = (state_q == CH_EMPTY);
        full_o  = (state_q == CH_FULL);
    end

    assign head_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor: watches NUM_CH ap_ctrl_chain handshakes and keeps
// per-channel start/done counts, start-to-done latency (last/min/max),
// output-stall cycles and FIFO error flags. Results are read through a
// channel-select readout port; finish freezes every update.
// Optional: define AP_MON_WATCHDOG_EN to add the TIMEOUT parameter and the
// sticky err_timeout output (FIFO head age reached TIMEOUT).
module ap_ctrl_perf_monitor
    import ap_mon_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int CNT_W   = CNT_W_DEF,
    parameter  int DEPTH   = 4,
`ifdef AP_MON_WATCHDOG_EN
    parameter  int TIMEOUT = 1024,
`endif
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int OCC_W   = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [CNT_W-1:0]  rd_starts,
    output logic [CNT_W-1:0]  rd_dones,
    output logic [CNT_W-1:0]  rd_lat_last,
    output logic [CNT_W-1:0]  rd_lat_min,
    output logic [CNT_W-1:0]  rd_lat_max,
    output logic [CNT_W-1:0]  rd_stall,
    output logic [OCC_W-1:0]  rd_outstanding,
    output logic [NUM_CH-1:0] err_overflow,
    output logic [NUM_CH-1:0] err_underflow
`ifdef AP_MON_WATCHDOG_EN
    ,
    output logic [NUM_CH-1:0] err_timeout
`endif
);

    logic [CNT_W-1:0]  ts_q;
    ch_stats_t         stats_vec [NUM_CH];
    logic [OCC_W-1:0]  occ_vec   [NUM_CH];
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] unf_set;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] unf_q;
`ifdef AP_MON_WATCHDOG_EN
    logic [NUM_CH-1:0] tmo_set;
    logic [NUM_CH-1:0] tmo_q;
`endif

    // Free-running timestamp; modulo wrap keeps single-wrap latencies exact.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     ts_q <= '0;
        else if (!finish) ts_q <= ts_q + 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             start_ev;
        logic             done_ev;
        logic             stall_ev;
        logic             bypass;
        logic             push;
        logic             pop;
        logic             lat_vld;
        logic [CNT_W-1:0] head;
        logic [CNT_W-1:0] age;
        logic [CNT_W-1:0] lat;
        logic [OCC_W-1:0] occ;
        logic             empty;
        logic             full;
        ch_stats_t        stats_q;
        ch_stats_t        stats_d;

        // Events are qualified by finish so a frozen monitor changes nothing.
        assign start_ev = ap_start[c] & ap_ready[c] & ~finish;
        assign done_ev  = ap_done[c] & ap_continue[c] & ~finish;
        assign stall_ev = ap_done[c] & ~ap_continue[c] & ~finish;

        // Empty FIFO with start and done together: the transaction passes
        // straight through with zero latency and never touches the FIFO.
        assign bypass  = start_ev & done_ev & empty;
        assign pop     = done_ev & ~empty;
        // A full FIFO still accepts a push when a pop frees a slot this cycle.
        assign push    = start_ev & ~bypass & (~full | pop);
        assign lat_vld = pop | bypass;

        assign ovf_set[c] = start_ev & full & ~pop;
        assign unf_set[c] = done_ev & empty & ~start_ev;

        assign age = ts_q - head;
        assign lat = bypass ? '0 : age;

`ifdef AP_MON_WATCHDOG_EN
        assign tmo_set[c] = ~finish & ~empty & (age >= CNT_W'(TIMEOUT));
`endif

        ap_mon_ts_fifo #(
            .DEPTH (DEPTH),
            .W     (CNT_W)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .push_i  (push),
            .pop_i   (pop),
            .din_i   (ts_q),
            .head_o  (head),
            .occ_o   (occ),
            .empty_o (empty),
            .full_o  (full)
        );

        // Statistics update for this cycle's events.
        always_comb begin
            stats_d = stats_q;
            if (start_ev) stats_d.starts = sat_inc(stats_q.starts);
            if (done_ev)  stats_d.dones  = sat_inc(stats_q.dones);
            if (stall_ev) stats_d.stall  = sat_inc(stats_q.stall);
            if (lat_vld) begin
                stats_d.lat_last = lat;
                if (lat < stats_q.lat_min) stats_d.lat_min = lat;
                if (lat > stats_q.lat_max) stats_d.lat_max = lat;
            end
        end

        // Statistics register.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) stats_q <= STATS_RESET;
            else          stats_q <= stats_d;
        end

        assign stats_vec[c] = stats_q;
        assign occ_vec[c]   = occ;
    end

    // Sticky error flags; the set terms are already blocked by finish.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            unf_q <= unf_q | unf_set;
        end
    end

    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

`ifdef AP_MON_WATCHDOG_EN
    // Sticky watchdog flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= tmo_q | tmo_set;
    end

    assign err_timeout = tmo_q;
`endif

    // Combinational readout; an unused channel number reads all zeros.
    always_comb begin
        rd_starts      = '0;
        rd_dones       = '0;
        rd_lat_last    = '0;
        rd_lat_min     = '0;
        rd_lat_max     = '0;
        rd_stall       = '0;
        rd_outstanding = '0;
        if (int'(rd_sel) < NUM_CH) begin
            rd_starts      = stats_vec[rd_sel].starts;
            rd_dones       = stats_vec[rd_sel].dones;
            rd_lat_last    = stats_vec[rd_sel].lat_last;
            rd_lat_min     = stats_vec[rd_sel].lat_min;
            rd_lat_max     = stats_vec[rd_sel].lat_max;
            rd_stall       = stats_vec[rd_sel].stall;
            rd_outstanding = occ_vec[rd_sel];
        end
    end

endmodule

// File: doc/ap_ctrl_perf_monitor.md
Name: ap_ctrl_perf_monitor

Overview:
- Synthesizable, multi-channel successor to the simulation-only dataflow status monitor.
- Watches NUM_CH ap_ctrl_chain handshakes (ap_start/ap_ready/ap_done/ap_continue) in parallel.
- Per channel it tracks outstanding transactions, start-to-done latency (last/min/max) and output-stall cycles.
- Sits beside HLS top/sub-modules; results are read through a channel-select readout port, frozen by finish.

Parameters:
- NUM_CH, 4, number of monitored handshake channels (1..16)
- CNT_W, 32, width of timestamp, latency and event counters
- DEPTH, 4, per-channel outstanding-start timestamp FIFO depth (power of 2, >=2)

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- ap_start  in  NUM_CH  per-channel ap_start
- ap_ready  in  NUM_CH  per-channel ap_ready
- ap_done  in  NUM_CH  per-channel ap_done
- ap_continue  in  NUM_CH  per-channel ap_continue (tie 1 for ap_ctrl_hs)
- finish  in  1  freeze all counters while high
- rd_sel  in  clog2(NUM_CH) (min 1)  readout channel select
- rd_starts  out  CNT_W  accepted starts on rd_sel
- rd_dones  out  CNT_W  accepted dones on rd_sel
- rd_lat_last  out  CNT_W  latency of most recent completed transaction
- rd_lat_min  out  CNT_W  minimum latency
- rd_lat_max  out  CNT_W  maximum latency
- rd_stall  out  CNT_W  cycles with ap_done=1, ap_continue=0
- rd_outstanding  out  clog2(DEPTH)+1  current FIFO occupancy
- err_overflow  out  NUM_CH  sticky: start accepted with FIFO full
- err_underflow  out  NUM_CH  sticky: done accepted with FIFO empty

Behaviour:
- Free-running timestamp ts (CNT_W) increments every cycle unless finish=1; wraps modulo 2^CNT_W. Latency = ts - stored_ts, modulo arithmetic, so a single wrap is correct.
- Start event: ap_start & ap_ready. Push ts into the channel FIFO; starts++.
- Done event: ap_done & ap_continue. Pop the FIFO head; lat = ts - head; dones++; lat_last=lat; lat_min=min; lat_max=max.
- Start and done in the same cycle: pop and push both happen; occupancy is unchanged. The done uses the head entry before the push, so an empty FIFO with simultaneous start+done gives latency 0 and no underflow.
- Stall event: ap_done & ~ap_continue; stall++.
- Full: a start with occupancy==DEPTH drops the push, sets err_overflow[ch] and still counts starts++.
- Empty: a done with occupancy==0 and no simultaneous start sets err_underflow[ch], counts dones++ and leaves latency registers unchanged.
- Event counters saturate at all-ones; they do not wrap.
- finish=1 blocks all updates (ts, FIFOs, counters, flags). Readout stays live.
- Readout is combinational from registers indexed by rd_sel. rd_sel >= NUM_CH reads all zeros.
- Per-channel state: EMPTY (occ=0), ACTIVE (0<occ<DEPTH), FULL (occ=DEPTH). Transitions are driven only by push/pop as above.
- Reset (async assert, sync release): ts, occupancy, counters, lat_last and lat_max go to 0; lat_min to all-ones; err flags to 0. All rd_* outputs read 0, except rd_lat_min, which reads all-ones. Reset mid-transaction discards every outstanding timestamp.

Optional Feature:
- Macro AP_MON_WATCHDOG_EN.
- Defined: parameter TIMEOUT (default 1024) and output err_timeout[NUM_CH] are added. err_timeout is sticky and set when the channel's FIFO head age (ts - head) reaches TIMEOUT while occupancy>0. It is cleared only by reset.
- Undefined: no timeout logic and no err_timeout port.

Decomposition:
- Package ap_mon_pkg holds the per-channel stats struct (starts, dones, lat_last/min/max, stall) and the constants CNT_MAX and LAT_MIN_INIT.
- Sub-module ap_mon_ts_fifo: DEPTH x CNT_W circular FIFO with push, pop and occupancy, one instance per channel via generate.

Test Plan:
- Reset, then no activity: all rd_* read 0 except rd_lat_min=0xFFFFFFFF; err flags are 0.
- Ch0: start at ts=10, done at ts=25 -> starts=1, dones=1, lat_last=min=max=15, outstanding=0.
- Ch1, DEPTH=4: five starts with no done -> outstanding=4, err_overflow[1]=1, starts=5. Then four dones -> outstanding=0 with no underflow.
- Ch2: ap_done=1 with ap_continue=0 for 7 cycles, then continue=1 -> stall=7, dones=1. A done with an empty FIFO -> err_underflow[2]=1.
- Ch3: start and done in the same cycle while occupancy=2 -> occupancy stays 2 and latency is computed from the old head. Assert finish, apply 10 start events -> counters unchanged.
- With the AP_MON_WATCHDOG_EN macro defined and TIMEOUT=50: start with no done for 50 cycles -> err_timeout[0] rises at age 50 and stays set after the done.
